au_op_sequencer: RTL

- Sequential initiator that drives the 4-bit combinational arithmetic unit (`arithmetic_unit`) and consumes its outputs.
- Accepts one command (A, B, op) per valid/ready handshake and drives registered operands onto the arithmetic unit's inputs.
- Waits a programmable settle time, then samples result/zero/overflow into response registers.
- Presents the response on a valid/ready output channel.
- Sits between the arithmetic unit and upstream control logic (keypad/serial front end).

---
 rtl/au_seq_pkg.sv | 23 ++
 rtl/au_seq_sat_counter.sv | 38 +++
 rtl/au_op_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/au_seq_pkg.sv
// rtl/au_seq_pkg.sv - shared op codes, FSM state type and defaults for au_op_sequencer
//
// Purpose: common definitions imported by au_op_sequencer and its sub-module.
// Contents:
//   OP_ADD/OP_SUB/OP_MUL/OP_DIV  arithmetic unit op codes
//   au_seq_state_e               sequencer FSM states (IDLE, DRIVE, RESP)
//   SETTLE_CYCLES_DEFAULT        default operand settle time in clock cycles
package au_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int SETTLE_CYCLES_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } au_seq_state_e;

endpackage

// File: rtl/au_seq_sat_counter.sv
// rtl/au_seq_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts enabled events, sticking at all-ones instead of wrapping.
// Ports:
//   clk_i    clock, rising edge
//   clr_i    synchronous clear (has priority over inc_i)
//   inc_i    increment enable
//   count_o  current count
module au_seq_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/au_op_sequencer.sv
// rtl/au_op_sequencer.sv - command/response sequencer around the 4-bit arithmetic unit
//
// Purpose: accepts (A, B, op) commands, holds them on the arithmetic unit's
// inputs for SETTLE_CYCLES clocks, captures result/flags and offers them on a
// valid/ready response channel.
// Optional feature macro: AU_SEQ_ERR_CNT_EN (saturating overflow counter on
// err_count; when undefined err_count is tied to zero).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a, cmd_b, cmd_op          command operands and op code
//   au_a, au_b, au_op             registered operands to the arithmetic unit
//   au_result, au_zero, au_overflow  arithmetic unit outputs
//   rsp_valid/rsp_ready           response handshake
//   rsp_result, rsp_zero, rsp_overflow  captured response
//   busy                          high whenever not IDLE
//   err_count                     saturating count of overflow responses
module au_op_sequencer
    import au_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_a,
    input  logic [3:0]           cmd_b,
    input  logic [1:0]           cmd_op,
    output logic [3:0]           au_a,
    output logic [3:0]           au_b,
    output logic [1:0]           au_op,
    input  logic [7:0]           au_result,
    input  logic                 au_zero,
    input  logic                 au_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_overflow,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("au_op_sequencer: SETTLE_CYCLES must be >= 1");
    end

    // One-bit counter is kept even for SETTLE_CYCLES=1 so the compare is uniform.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    au_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       au_a_q, au_a_d;
    logic [3:0]       au_b_q, au_b_d;
    logic [1:0]       au_op_q, au_op_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;

    logic             capture;

    // Sampling edge: last settle cycle of DRIVE.
    assign capture = (state_q == DRIVE) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        au_a_d         = au_a_q;
        au_b_d         = au_b_q;
        au_op_d        = au_op_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_valid_d    = rsp_valid_q;
        cmd_ready_d    = cmd_ready_q;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    au_a_d      = cmd_a;
                    au_b_d      = cmd_b;
                    au_op_d     = cmd_op;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (capture) begin
                    rsp_result_d   = au_result;
                    rsp_zero_d     = au_zero;
                    rsp_overflow_d = au_overflow;
                    rsp_valid_d    = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            au_a_q         <= '0;
            au_b_q         <= '0;
            au_op_q        <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            au_a_q         <= au_a_d;
            au_b_q         <= au_b_d;
            au_op_q        <= au_op_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_valid_q    <= rsp_valid_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign au_a         = au_a_q;
    assign au_b         = au_b_q;
    assign au_op        = au_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;

`ifdef AU_SEQ_ERR_CNT_EN
    au_seq_sat_counter #(
        .WIDTH(ERR_CNT_W)
    ) u_err_cnt (
        .clk_i  (clk),
        .clr_i  (rst),
        .inc_i  (capture && au_overflow),
        .count_o(err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule
